mul_ctrl: RTL and testbench

Job sequencer for the MUL grouped-multiply unit. It accepts job descriptors (iteration count, reads per iteration, weight base address), holds a local weight buffer, and configures MUL. It then delivers exactly one new weight per iteration on the exact cycle of each iteration boundary, so MUL never multiplies with a stale or early weight. It sits between the layer-level control FSM and one MUL instance.

---
 rtl/mul_ctrl_pkg.sv | 17 +
 rtl/mul_ctrl_weight_buf.sv | 25 ++
 rtl/mul_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mul_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types for the MUL job sequencer: FSM state encoding and stats helpers.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    MUL_CTRL_IDLE  = 2'd0,
    MUL_CTRL_FETCH = 2'd1,
    MUL_CTRL_RUN   = 2'd2,
    MUL_CTRL_DONE  = 2'd3
  } mul_ctrl_state_e;

  localparam int unsigned STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mul_ctrl_weight_buf.sv
// Weight buffer: synchronous write, registered read-first read port, contents not reset.
module weight_buf #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned LOG_WEIGHT_DEPTH = 6
) (
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic [LOG_WEIGHT_DEPTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_en_i,
  input  logic [LOG_WEIGHT_DEPTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o
);

  localparam int unsigned DEPTH = 1 << LOG_WEIGHT_DEPTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Read and write in one process: a same-address collision returns the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/mul_ctrl.sv
// MUL job sequencer: configures MUL and delivers one weight per iteration boundary.
// Optional MUL_CTRL_STATS_EN adds saturating run/stall cycle counters.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned LOG_MAX_ITERS          = 16,
  parameter int unsigned LOG_MAX_READS_PER_ITER = 16,
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned LOG_WEIGHT_DEPTH       = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              job_valid_in,
  output logic                              job_ready_out,
  input  logic [LOG_MAX_ITERS-1:0]          job_num_iters_in,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_num_reads_in,
  input  logic [LOG_WEIGHT_DEPTH-1:0]       job_wbase_in,
  input  logic                              wbuf_write_in,
  input  logic [LOG_WEIGHT_DEPTH-1:0]       wbuf_addr_in,
  input  logic [DATA_WIDTH-1:0]             wbuf_data_in,
  output logic                              mul_configure_out,
  output logic [LOG_MAX_ITERS-1:0]          mul_num_iters_out,
  output logic [LOG_MAX_READS_PER_ITER-1:0] mul_num_reads_per_iter_out,
  output logic [DATA_WIDTH-1:0]             mul_weight_data_out,
  output logic                              mul_weight_valid_out,
  input  logic                              mul_op_in,
  output logic                              done_out,
  output logic                              busy_out
`ifdef MUL_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]                 stat_run_cycles_out,
  output logic [STAT_W-1:0]                 stat_stall_cycles_out
`endif
);

  mul_ctrl_state_e state_q, state_d;

  logic [LOG_MAX_ITERS-1:0]          niters_q, niters_d, it_cnt_q, it_cnt_d;
  logic [LOG_MAX_READS_PER_ITER-1:0] nreads_q, nreads_d, rd_cnt_q, rd_cnt_d;
  logic [LOG_WEIGHT_DEPTH-1:0]       pf_addr_q, pf_addr_d, rd_addr;
  logic                              rd_en;
  logic [DATA_WIDTH-1:0]             rd_data;
  logic                              accept;

  weight_buf #(
    .DATA_WIDTH      (DATA_WIDTH),
    .LOG_WEIGHT_DEPTH(LOG_WEIGHT_DEPTH)
  ) u_weight_buf (
    .clk_i    (clk),
    .wr_en_i  (wbuf_write_in),
    .wr_addr_i(wbuf_addr_in),
    .wr_data_i(wbuf_data_in),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign accept = (state_q == MUL_CTRL_IDLE) && job_valid_in;

  // pf_addr_q is the address of the word currently held on the buffer read port.
  always_comb begin
    state_d              = state_q;
    niters_d             = niters_q;
    nreads_d             = nreads_q;
    it_cnt_d             = it_cnt_q;
    rd_cnt_d             = rd_cnt_q;
    pf_addr_d            = pf_addr_q;
    rd_en                = 1'b0;
    rd_addr              = pf_addr_q + LOG_WEIGHT_DEPTH'(1);
    mul_configure_out    = 1'b0;
    mul_weight_valid_out = 1'b0;
    unique case (state_q)
      MUL_CTRL_IDLE: begin
        if (job_valid_in) begin
          niters_d  = job_num_iters_in;
          nreads_d  = job_num_reads_in;
          it_cnt_d  = '0;
          rd_cnt_d  = '0;
          pf_addr_d = job_wbase_in;
          if (job_num_iters_in == '0 || job_num_reads_in == '0) begin
            state_d = MUL_CTRL_DONE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = job_wbase_in;
            state_d = MUL_CTRL_FETCH;
          end
        end
      end
      MUL_CTRL_FETCH: begin
        mul_configure_out    = 1'b1;
        mul_weight_valid_out = 1'b1;
        rd_en                = 1'b1;
        pf_addr_d            = pf_addr_q + LOG_WEIGHT_DEPTH'(1);
        state_d              = MUL_CTRL_RUN;
      end
      MUL_CTRL_RUN: begin
        if (mul_op_in) begin
          if (rd_cnt_q == nreads_q - LOG_MAX_READS_PER_ITER'(1)) begin
            rd_cnt_d = '0;
            if (it_cnt_q == niters_q - LOG_MAX_ITERS'(1)) begin
              state_d = MUL_CTRL_DONE;
            end else begin
              mul_weight_valid_out = 1'b1;
              rd_en                = 1'b1;
              pf_addr_d            = pf_addr_q + LOG_WEIGHT_DEPTH'(1);
              it_cnt_d             = it_cnt_q + LOG_MAX_ITERS'(1);
            end
          end else begin
            rd_cnt_d = rd_cnt_q + LOG_MAX_READS_PER_ITER'(1);
          end
        end
      end
      MUL_CTRL_DONE: begin
        state_d = MUL_CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MUL_CTRL_IDLE;
      niters_q  <= '0;
      nreads_q  <= '0;
      it_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      pf_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      niters_q  <= niters_d;
      nreads_q  <= nreads_d;
      it_cnt_q  <= it_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      pf_addr_q <= pf_addr_d;
    end
  end

  assign job_ready_out              = (state_q == MUL_CTRL_IDLE) && !rst;
  assign busy_out                   = (state_q != MUL_CTRL_IDLE);
  assign done_out                   = (state_q == MUL_CTRL_DONE);
  assign mul_num_iters_out          = busy_out ? niters_q : '0;
  assign mul_num_reads_per_iter_out = busy_out ? nreads_q : '0;
  assign mul_weight_data_out        = mul_weight_valid_out ? rd_data : '0;

`ifdef MUL_CTRL_STATS_EN
  logic [STAT_W-1:0] run_q, run_d, stall_q, stall_d;

  always_comb begin
    run_d   = run_q;
    stall_d = stall_q;
    if (accept) begin
      run_d   = '0;
      stall_d = '0;
    end else if (state_q == MUL_CTRL_RUN) begin
      run_d = sat_inc(run_q);
      if (!mul_op_in) stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      stall_q <= '0;
    end else begin
      run_q   <= run_d;
      stall_q <= stall_d;
    end
  end

  assign stat_run_cycles_out   = run_q;
  assign stat_stall_cycles_out = stall_q;
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: job table, randomized jobs vs. a weight-schedule model, corner sequences.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid_in;
  logic        job_ready_out;
  logic [15:0] job_num_iters_in;
  logic [15:0] job_num_reads_in;
  logic [5:0]  job_wbase_in;
  logic        wbuf_write_in;
  logic [5:0]  wbuf_addr_in;
  logic [7:0]  wbuf_data_in;
  logic        mul_configure_out;
  logic [15:0] mul_num_iters_out;
  logic [15:0] mul_num_reads_per_iter_out;
  logic [7:0]  mul_weight_data_out;
  logic        mul_weight_valid_out;
  logic        mul_op_in;
  logic        done_out;
  logic        busy_out;
`ifdef MUL_CTRL_STATS_EN
  logic [31:0] stat_run;
  logic [31:0] stat_stall;
`endif

  mul_ctrl #(
    .LOG_MAX_ITERS         (16),
    .LOG_MAX_READS_PER_ITER(16),
    .DATA_WIDTH            (8),
    .LOG_WEIGHT_DEPTH      (6)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .job_valid_in              (job_valid_in),
    .job_ready_out             (job_ready_out),
    .job_num_iters_in          (job_num_iters_in),
    .job_num_reads_in          (job_num_reads_in),
    .job_wbase_in              (job_wbase_in),
    .wbuf_write_in             (wbuf_write_in),
    .wbuf_addr_in              (wbuf_addr_in),
    .wbuf_data_in              (wbuf_data_in),
    .mul_configure_out         (mul_configure_out),
    .mul_num_iters_out         (mul_num_iters_out),
    .mul_num_reads_per_iter_out(mul_num_reads_per_iter_out),
    .mul_weight_data_out       (mul_weight_data_out),
    .mul_weight_valid_out      (mul_weight_valid_out),
    .mul_op_in                 (mul_op_in),
    .done_out                  (done_out),
    .busy_out                  (busy_out)
`ifdef MUL_CTRL_STATS_EN
    ,
    .stat_run_cycles_out       (stat_run),
    .stat_stall_cycles_out     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  logic [7:0]  wmem [64];
  logic [7:0]  got_w  [$];
  int unsigned got_at [$];

  typedef struct {
    int unsigned iters;
    int unsigned reads;
    int unsigned wbase;
    int unsigned gap;
    int unsigned exp_ops;
  } job_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns one cycle later, just after the next falling edge.
  task automatic wbuf_wr(input int unsigned a, input logic [7:0] d);
    wbuf_write_in = 1'b1;
    wbuf_addr_in  = 6'(a);
    wbuf_data_in  = d;
    wmem[a % 64]  = d;
    @(negedge clk);
    wbuf_write_in = 1'b0;
  endtask

  // Model: the k-th iteration's weight is the buffer word at (wbase+k) mod 64 as of job start;
  // weight k>0 appears together with operation number k*reads; done follows op iters*reads.
  task automatic run_job(input int unsigned iters, input int unsigned reads, input int unsigned wbase,
                         input int unsigned gap, input int unsigned wr_op, input int unsigned wr_addr,
                         input logic [7:0] wr_data, output int unsigned ops, output int unsigned cycles);
    int unsigned total;
    int unsigned guard;
    logic [7:0]  exp_w [$];
    logic        op;
    logic        exp_v;
    total  = iters * reads;
    ops    = 0;
    cycles = 0;
    guard  = 0;
    got_w.delete();
    got_at.delete();
    while (!job_ready_out && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_job", {31'd0, job_ready_out}, 32'd1);
    if (total != 0)
      for (int unsigned k = 0; k < iters; k++) exp_w.push_back(wmem[(wbase + k) % 64]);
    job_valid_in     = 1'b1;
    job_num_iters_in = 16'(iters);
    job_num_reads_in = 16'(reads);
    job_wbase_in     = 6'(wbase);
    @(negedge clk);
    job_valid_in = 1'b0;
    #1;
    if (total == 0) begin
      check("zero_done", {31'd0, done_out}, 32'd1);
      check("zero_no_cfg", {31'd0, mul_configure_out}, 32'd0);
      check("zero_no_wvalid", {31'd0, mul_weight_valid_out}, 32'd0);
      @(negedge clk);
      #1;
      check("zero_ready_after", {31'd0, job_ready_out}, 32'd1);
      check("zero_done_once", {31'd0, done_out}, 32'd0);
      return;
    end
    check("cfg", {31'd0, mul_configure_out}, 32'd1);
    check("cfg_wvalid", {31'd0, mul_weight_valid_out}, 32'd1);
    check("cfg_wdata", {24'd0, mul_weight_data_out}, {24'd0, exp_w[0]});
    check("cfg_iters", {16'd0, mul_num_iters_out}, iters);
    check("cfg_reads", {16'd0, mul_num_reads_per_iter_out}, reads);
    got_w.push_back(mul_weight_data_out);
    got_at.push_back(0);
    while (ops < total && cycles < total * 20 + 50) begin
      @(negedge clk);
      op        = ($urandom_range(99) >= gap);
      mul_op_in = op;
      if (op && wr_op != 0 && ops + 1 == wr_op) begin
        wbuf_write_in = 1'b1;
        wbuf_addr_in  = 6'(wr_addr);
        wbuf_data_in  = wr_data;
        wmem[wr_addr % 64] = wr_data;
      end else begin
        wbuf_write_in = 1'b0;
      end
      #1;
      cycles++;
      if (op) ops++;
      exp_v = op && (ops % reads == 0) && (ops < total);
      check("run_wvalid", {31'd0, mul_weight_valid_out}, {31'd0, exp_v});
      if (exp_v) begin
        check("run_wdata", {24'd0, mul_weight_data_out}, {24'd0, exp_w[ops / reads]});
        got_w.push_back(mul_weight_data_out);
        got_at.push_back(ops);
      end
      check("run_no_done", {31'd0, done_out}, 32'd0);
      check("run_no_cfg", {31'd0, mul_configure_out}, 32'd0);
    end
    check("run_all_ops", ops, total);
    @(negedge clk);
    mul_op_in     = 1'b0;
    wbuf_write_in = 1'b0;
    #1;
    check("done_pulse", {31'd0, done_out}, 32'd1);
    check("done_no_wvalid", {31'd0, mul_weight_valid_out}, 32'd0);
    check("done_busy", {31'd0, busy_out}, 32'd1);
`ifdef MUL_CTRL_STATS_EN
    check("stat_run", stat_run, cycles);
    check("stat_stall", stat_stall, cycles - total);
`endif
    @(negedge clk);
    #1;
    check("idle_ready", {31'd0, job_ready_out}, 32'd1);
    check("idle_done_low", {31'd0, done_out}, 32'd0);
    check("idle_iters_zero", {16'd0, mul_num_iters_out}, 32'd0);
  endtask

  job_vec_t    vecs [7];
  int unsigned ops, cyc;
  logic [7:0]  old_w, new_w;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{iters: 1, reads: 1, wbase:  5, gap:  0, exp_ops:  1};
    vecs[1] = '{iters: 2, reads: 5, wbase: 20, gap: 40, exp_ops: 10};
    vecs[2] = '{iters: 3, reads: 3, wbase: 40, gap: 25, exp_ops:  9};
    vecs[3] = '{iters: 5, reads: 2, wbase: 60, gap: 10, exp_ops: 10};
    vecs[4] = '{iters: 1, reads: 7, wbase: 33, gap: 50, exp_ops:  7};
    vecs[5] = '{iters: 0, reads: 3, wbase:  1, gap:  0, exp_ops:  0};
    vecs[6] = '{iters: 4, reads: 0, wbase:  2, gap:  0, exp_ops:  0};

    rst = 1'b1; job_valid_in = 1'b0; job_num_iters_in = '0; job_num_reads_in = '0;
    job_wbase_in = '0; wbuf_write_in = 1'b0; wbuf_addr_in = '0; wbuf_data_in = '0; mul_op_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_low", {31'd0, job_ready_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_cfg", {31'd0, mul_configure_out}, 32'd0);
    check("rst_wvalid", {31'd0, mul_weight_valid_out}, 32'd0);
    check("rst_iters", {16'd0, mul_num_iters_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, job_ready_out}, 32'd1);

    for (int unsigned a = 0; a < 64; a++) wbuf_wr(a, 8'($urandom));

    // op pulses while idle must not start anything
    mul_op_in = 1'b1;
    @(negedge clk);
    #1;
    check("idle_op_ignored", {30'd0, busy_out, done_out}, 32'd0);
    mul_op_in = 1'b0;

    // basic job: weights 3,5,7,9 at ops 0(configure),2,4,6
    wbuf_wr(0, 8'd3); wbuf_wr(1, 8'd5); wbuf_wr(2, 8'd7); wbuf_wr(3, 8'd9);
    run_job(4, 2, 0, 0, 0, 0, 8'd0, ops, cyc);
    check("basic_count", got_w.size(), 32'd4);
    if (got_w.size() == 4) begin
      check("basic_w0", {24'd0, got_w[0]}, 32'd3);
      check("basic_w1", {24'd0, got_w[1]}, 32'd5);
      check("basic_w2", {24'd0, got_w[2]}, 32'd7);
      check("basic_w3", {24'd0, got_w[3]}, 32'd9);
      check("basic_at1", got_at[1], 32'd2);
      check("basic_at2", got_at[2], 32'd4);
      check("basic_at3", got_at[3], 32'd6);
    end

    // back-to-back boundaries, no bubbles
    run_job(3, 1, 1, 0, 0, 0, 8'd0, ops, cyc);
    check("b2b_cycles", cyc, 32'd3);
    check("b2b_count", got_w.size(), 32'd3);
    if (got_w.size() == 3) begin
      check("b2b_w1", {24'd0, got_w[1]}, 32'd7);
      check("b2b_w2", {24'd0, got_w[2]}, 32'd9);
      check("b2b_at2", got_at[2], 32'd2);
    end

    // address wrap
    wbuf_wr(62, 8'hA1); wbuf_wr(63, 8'hB2); wbuf_wr(0, 8'hC3);
    run_job(3, 2, 62, 20, 0, 0, 8'd0, ops, cyc);
    check("wrap_count", got_w.size(), 32'd3);
    if (got_w.size() == 3) begin
      check("wrap_w62", {24'd0, got_w[0]}, 32'hA1);
      check("wrap_w63", {24'd0, got_w[1]}, 32'hB2);
      check("wrap_w0", {24'd0, got_w[2]}, 32'hC3);
    end

    // table of jobs including zero counts
    for (int unsigned i = 0; i < 7; i++) begin
      run_job(vecs[i].iters, vecs[i].reads, vecs[i].wbase, vecs[i].gap, 0, 0, 8'd0, ops, cyc);
      check("table_ops", ops, vecs[i].exp_ops);
    end

    // write colliding with the prefetch read of address 12 (issued at op 2) delivers the old word
    old_w = wmem[12];
    new_w = ~old_w;
    run_job(3, 2, 10, 0, 2, 12, new_w, ops, cyc);
    if (got_w.size() == 3) check("collide_old", {24'd0, got_w[2]}, {24'd0, old_w});
    else check("collide_count", got_w.size(), 32'd3);
    run_job(1, 1, 12, 0, 0, 0, 8'd0, ops, cyc);
    if (got_w.size() == 1) check("collide_new", {24'd0, got_w[0]}, {24'd0, new_w});
    else check("collide_new_count", got_w.size(), 32'd1);

    // reset mid-RUN
    job_valid_in = 1'b1; job_num_iters_in = 16'd4; job_num_reads_in = 16'd3; job_wbase_in = 6'd0;
    @(negedge clk);
    job_valid_in = 1'b0;
    @(negedge clk);
    mul_op_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready_low", {31'd0, job_ready_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mul_op_in = 1'b0;
    #1;
    check("midrst_outputs", {26'd0, busy_out, done_out, mul_configure_out, mul_weight_valid_out,
                             |mul_num_iters_out, |mul_num_reads_per_iter_out}, 32'd0);
    check("midrst_wdata", {24'd0, mul_weight_data_out}, 32'd0);
    check("midrst_ready", {31'd0, job_ready_out}, 32'd1);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_done", {31'd0, done_out}, 32'd0);
    end
    run_job(2, 3, 7, 30, 0, 0, 8'd0, ops, cyc);

    // randomized jobs
    for (int unsigned j = 0; j < 15; j++) begin
      int unsigned it, rd, wb, gp;
      wbuf_wr($urandom_range(63), 8'($urandom));
      wbuf_wr($urandom_range(63), 8'($urandom));
      it = $urandom_range(6, 1);
      rd = $urandom_range(5, 1);
      wb = $urandom_range(63);
      gp = $urandom_range(60);
      run_job(it, rd, wb, gp, 0, 0, 8'd0, ops, cyc);
      check("rand_weights", got_w.size(), it);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
